rv_alu_mdu: RTL and testbench

Parametrised successor to the RV32I execute-stage ALU. It adds XLEN-generic integer ALU operations and an optional iterative multiply/divide unit (RISC-V M extension), with operand forwarding from its own last result. It sits between decode and writeback and uses a valid/ready input handshake. Single-cycle ops complete in one clock; mul/div ops stall the front end via `in_ready`.

---
 rtl/rv_alu_mdu.sv | 204 ++++++++++++++++++++
 tb/tb_rv_alu_mdu.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_alu_mdu.sv
// rv_alu_mdu: XLEN-generic RISC-V execute-stage ALU with an optional iterative
// shift-add multiplier / restoring divider and forwarding from its own last result.
module rv_alu_mdu #(
    parameter int XLEN   = 32,
    parameter bit MDU_EN = 1'b1,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      a_rs_idx,
    input  logic [4:0]      b_rs_idx,
    input  logic [4:0]      rd_in,
    output logic            out_valid,
    output logic [XLEN-1:0] c,
    output logic [4:0]      rd,
    output logic            illegal
);
    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
    state_e state, state_next;

    logic            fwd_ok;
    logic [XLEN-1:0] a_eff, b_eff;

    // b_rs_idx == 0 marks an immediate, which must never be replaced.
    assign a_eff = (FWD_EN && fwd_ok && (a_rs_idx == rd)) ? c : a;
    assign b_eff = (FWD_EN && fwd_ok && (b_rs_idx != 5'd0) && (b_rs_idx == rd)) ? c : b;

    logic is_alu, is_mdu, is_div, is_rem, a_sgn, b_sgn;
    logic div_zero, div_ovf, multi, op_illegal, accept;

    assign is_alu     = (op < 5'd10);
    assign is_mdu     = MDU_EN && (op[4:3] == 2'b10);
    assign is_div     = is_mdu && op[2];
    assign is_rem     = op[1];
    assign a_sgn      = is_div ? ~op[0] : ((op[1:0] == 2'b01) || (op[1:0] == 2'b10));
    assign b_sgn      = is_div ? ~op[0] : (op[1:0] == 2'b01);
    assign div_zero   = is_div && (b_eff == '0);
    assign div_ovf    = is_div && !op[0] && (a_eff == MIN_NEG) && (b_eff == '1);
    assign multi      = is_mdu && !div_zero && !div_ovf;
    assign op_illegal = !is_alu && !is_mdu;
    assign in_ready   = (state == IDLE);
    assign accept     = in_valid && in_ready && !flush;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    assign a_neg = a_sgn && a_eff[XLEN-1];
    assign b_neg = b_sgn && b_eff[XLEN-1];
    assign a_mag = a_neg ? -a_eff : a_eff;
    assign b_mag = b_neg ? -b_eff : b_eff;

    logic [XLEN-1:0] single_res;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        single_res = '0;
        if (div_zero) begin
            single_res = is_rem ? a_eff : '1;
        end else if (div_ovf) begin
            single_res = is_rem ? '0 : a_eff;
        end else begin
            case (op)
                OP_ADD:  single_res = a_eff + b_eff;
                OP_SUB:  single_res = a_eff - b_eff;
                OP_SLL:  single_res = a_eff << b_eff[SW-1:0];
                OP_SLT:  single_res = {{(XLEN-1){1'b0}}, $signed(a_eff) < $signed(b_eff)};
                OP_SLTU: single_res = {{(XLEN-1){1'b0}}, a_eff < b_eff};
                OP_XOR:  single_res = a_eff ^ b_eff;
                OP_SRL:  single_res = a_eff >> b_eff[SW-1:0];
                OP_SRA:  single_res = $signed(a_eff) >>> b_eff[SW-1:0];
                OP_OR:   single_res = a_eff | b_eff;
                OP_AND:  single_res = a_eff & b_eff;
                default: single_res = '0;
            endcase
        end
    end

    // hi/lo hold accumulator/multiplier for MUL*, remainder/quotient for DIV*.
    logic [XLEN-1:0] hi, lo, opnd;
    logic [2:0]      mop;
    logic            neg_q, neg_r;
    logic [4:0]      rd_hold;
    logic [SW-1:0]   cnt;

    logic [XLEN:0]   mul_sum, rem_sh, rem_diff;
    logic [XLEN-1:0] hi_next, lo_next;

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        rem_sh   = {hi, lo[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opnd};
        if (mop[2]) begin
            hi_next = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], ~rem_diff[XLEN]};
        end else begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_s = neg_q ? -{hi, lo} : {hi, lo};
        if (!mop[2]) begin
            fix_res = (mop[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end else if (mop[1]) begin
            fix_res = neg_r ? -hi : hi;
        end else begin
            fix_res = neg_q ? -lo : lo;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && multi) state_next = CALC;
            CALC:    if (cnt == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            c         <= '0;
            rd        <= '0;
            illegal   <= 1'b0;
            fwd_ok    <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            opnd      <= '0;
            mop       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            rd_hold   <= '0;
            cnt       <= '0;
        end else begin
            out_valid <= 1'b0;
            if (flush) begin
                fwd_ok <= 1'b0;
            end else begin
                if (accept && !multi) begin
                    c         <= op_illegal ? '0 : single_res;
                    rd        <= rd_in;
                    illegal   <= op_illegal;
                    out_valid <= 1'b1;
                    fwd_ok    <= (rd_in != 5'd0);
                end
                if (accept && multi) begin
                    hi      <= '0;
                    lo      <= is_div ? a_mag : b_mag;
                    opnd    <= is_div ? b_mag : a_mag;
                    mop     <= op[2:0];
                    neg_q   <= a_neg ^ b_neg;
                    neg_r   <= a_neg;
                    rd_hold <= rd_in;
                    cnt     <= SW'(XLEN - 1);
                end
                if (state == CALC) begin
                    hi  <= hi_next;
                    lo  <= lo_next;
                    cnt <= cnt - 1'b1;
                end
                if (state == FIX) begin
                    c         <= fix_res;
                    rd        <= rd_hold;
                    illegal   <= 1'b0;
                    out_valid <= 1'b1;
                    fwd_ok    <= (rd_hold != 5'd0);
                end
            end
        end
    end
endmodule

// File: tb/tb_rv_alu_mdu.sv
// Scoreboard bench for rv_alu_mdu: three instances (default, MDU disabled, XLEN=64)
// driven by directed vectors; a negedge monitor pops expectations on each out_valid.
module tb_rv_alu_mdu;
    typedef struct {
        int          dut;
        logic [63:0] c;
        logic [4:0]  rd;
        logic        ill;
        int          due;
    } exp_t;

    localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLT = 5'd3, SLTU = 5'd4, SRA = 5'd7;
    localparam logic [4:0] MUL = 5'd16, MULH = 5'd17, MULHSU = 5'd18, MULHU = 5'd19;
    localparam logic [4:0] DIV = 5'd20, DIVU = 5'd21, REM = 5'd22, REMU = 5'd23;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [2:0]  vld;
    logic [4:0]  op, ars, brs, rdi;
    logic [63:0] a, b;
    logic [2:0]  ovs, rdys, ills;
    logic [31:0] c0, c1;
    logic [63:0] c2;
    logic [4:0]  rd0, rd1, rd2;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rv_alu_mdu #(.XLEN(32), .MDU_EN(1'b1), .FWD_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(vld[0]), .in_ready(rdys[0]), .flush(flush),
        .op(op), .a(a[31:0]), .b(b[31:0]), .a_rs_idx(ars), .b_rs_idx(brs), .rd_in(rdi),
        .out_valid(ovs[0]), .c(c0), .rd(rd0), .illegal(ills[0]));

    rv_alu_mdu #(.XLEN(32), .MDU_EN(1'b0), .FWD_EN(1'b1)) u_nomdu (
        .clk(clk), .reset(reset), .in_valid(vld[1]), .in_ready(rdys[1]), .flush(flush),
        .op(op), .a(a[31:0]), .b(b[31:0]), .a_rs_idx(ars), .b_rs_idx(brs), .rd_in(rdi),
        .out_valid(ovs[1]), .c(c1), .rd(rd1), .illegal(ills[1]));

    rv_alu_mdu #(.XLEN(64), .MDU_EN(1'b1), .FWD_EN(1'b1)) u_x64 (
        .clk(clk), .reset(reset), .in_valid(vld[2]), .in_ready(rdys[2]), .flush(flush),
        .op(op), .a(a), .b(b), .a_rs_idx(ars), .b_rs_idx(brs), .rd_in(rdi),
        .out_valid(ovs[2]), .c(c2), .rd(rd2), .illegal(ills[2]));

    function automatic logic [63:0] c_of(input int k);
        case (k)
            0:       return {32'b0, c0};
            1:       return {32'b0, c1};
            default: return c2;
        endcase
    endfunction

    function automatic logic [4:0] rd_of(input int k);
        case (k)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                if (ovs[k]) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_out_valid dut%0d: got c=%h, required no output", k, c_of(k));
                    end else begin
                        mon_e = sb.pop_front();
                        check($sformatf("dut%0d_rd%0d_which", k, mon_e.rd), 64'(k), 64'(mon_e.dut));
                        check($sformatf("dut%0d_rd%0d_c", k, mon_e.rd), c_of(k), mon_e.c);
                        check($sformatf("dut%0d_rd%0d_rd", k, mon_e.rd), 64'(rd_of(k)), 64'(mon_e.rd));
                        check($sformatf("dut%0d_rd%0d_illegal", k, mon_e.rd), 64'(ills[k]), 64'(mon_e.ill));
                        check($sformatf("dut%0d_rd%0d_latency", k, mon_e.rd), 64'(cyc), 64'(mon_e.due));
                    end
                end
            end
        end
    end

    task automatic issue(input int k, input logic [4:0] o, input logic [63:0] av, input logic [63:0] bv,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rdv,
                         input logic [63:0] ec, input logic ei, input int extra, input bit track);
        int n = 0;
        while (!rdys[k] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdys[k]) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout dut%0d: in_ready low after %0d cycles, required high", k, n);
        end
        op = o; a = av; b = bv; ars = ra; brs = rb; rdi = rdv;
        vld[k] = 1'b1;
        if (track) sb.push_back('{k, ec, rdv, ei, cyc + 1 + extra});
        @(posedge clk);
        #1;
        vld[k] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit low_ok;
        reset = 1'b0; flush = 1'b0; vld = '0; op = '0; a = '0; b = '0;
        ars = '0; brs = '0; rdi = '0;
        #2 reset = 1'b1;
        #1;
        check("reset_out_valid", 64'(ovs), 64'd0);
        check("reset_in_ready", 64'(rdys), 64'h7);
        check("reset_illegal", 64'(ills), 64'd0);
        check("reset_c", {32'b0, c0}, 64'd0);
        check("reset_rd", 64'(rd0), 64'd0);
        check("reset_c64", c2, 64'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;

        // Single-cycle ALU ops, back-to-back
        issue(0, ADD,   64'h7FFF_FFFF, 64'h1,         0, 0, 1, 64'h8000_0000, 0, 0, 1);
        issue(0, SRA,   64'h8000_0000, 64'd31,        0, 0, 2, 64'hFFFF_FFFF, 0, 0, 1);
        issue(0, SLTU,  64'h1,         64'hFFFF_FFFF, 0, 0, 3, 64'h1,         0, 0, 1);
        issue(0, SLT,   64'hFFFF_FFFF, 64'h1,         0, 0, 4, 64'h1,         0, 0, 1);
        issue(0, 5'd12, 64'h5,         64'h6,         0, 0, 6, 64'h0,         1, 0, 1);

        // Division fast-paths
        issue(0, DIV,  64'h7,         64'h0,         0, 0, 7,  64'hFFFF_FFFF, 0, 0, 1);
        issue(0, REMU, 64'h7,         64'h0,         0, 0, 8,  64'h7,         0, 0, 1);
        issue(0, DIV,  64'h8000_0000, 64'hFFFF_FFFF, 0, 0, 9,  64'h8000_0000, 0, 0, 1);
        issue(0, REM,  64'h8000_0000, 64'hFFFF_FFFF, 0, 0, 10, 64'h0,         0, 0, 1);

        // Multiply
        issue(0, MULH,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 0, 11, 64'h0, 0, 33, 1);
        issue(0, MULHU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 0, 12, 64'hFFFF_FFFE, 0, 33, 1);
        low_ok = 1'b1;
        for (int i = 0; i < 33; i++) begin
            if (rdys[0]) low_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        check("mulhu_in_ready_low", 64'(low_ok), 64'd1);
        check("mulhu_in_ready_after_fix", 64'(rdys[0]), 64'd1);
        issue(0, MULHSU, 64'hFFFF_FFFF, 64'h2,         0, 0, 13, 64'hFFFF_FFFF, 0, 33, 1);
        issue(0, MUL,    64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 0, 14, 64'h1,         0, 33, 1);

        // Iterative divide
        issue(0, DIV,  64'hFFFF_FFF9, 64'h2, 0, 0, 15, 64'hFFFF_FFFD, 0, 33, 1);
        issue(0, REM,  64'hFFFF_FFF9, 64'h2, 0, 0, 16, 64'hFFFF_FFFF, 0, 33, 1);
        issue(0, DIVU, 64'd100,       64'd7, 0, 0, 17, 64'd14,        0, 33, 1);
        issue(0, REMU, 64'd100,       64'd7, 0, 0, 18, 64'd2,         0, 33, 1);

        // Forwarding: taken with rd=5, suppressed after an rd=0 result, and into b
        issue(0, ADD, 64'd3, 64'd4,   0, 0,  5,  64'd7,         0, 0, 1);
        issue(0, SUB, 64'd0, 64'd2,   5, 0,  19, 64'd5,         0, 0, 1);
        issue(0, ADD, 64'd3, 64'd4,   0, 0,  0,  64'd7,         0, 0, 1);
        issue(0, SUB, 64'd0, 64'd2,   0, 0,  20, 64'hFFFF_FFFE, 0, 0, 1);
        issue(0, ADD, 64'd1, 64'd100, 0, 20, 21, 64'hFFFF_FFFF, 0, 0, 1);
        drain();

        // Flush at CALC cycle 10 of a DIVU, then a flushed same-cycle request
        issue(0, DIVU, 64'd1000, 64'd3, 0, 0, 22, 64'd0, 0, 33, 0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(rdys[0]), 64'd1);
        check("flush_c_held", {32'b0, c0}, 64'hFFFF_FFFF);
        check("flush_rd_held", 64'(rd0), 64'd21);
        op = ADD; a = 64'd1; b = 64'd1; ars = '0; brs = '0; rdi = 5'd23;
        vld[0] = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        flush = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        check("flush_drop_c_held", {32'b0, c0}, 64'hFFFF_FFFF);

        // MDU disabled: mul/div opcodes are illegal
        issue(1, MUL,   64'd3, 64'd4, 0, 0, 1, 64'd0, 1, 0, 1);
        issue(1, 5'd12, 64'd3, 64'd4, 0, 0, 2, 64'd0, 1, 0, 1);
        issue(1, ADD,   64'd2, 64'd3, 0, 0, 3, 64'd5, 0, 0, 1);

        // XLEN=64
        issue(2, MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1,
              64'hFFFF_FFFF_FFFF_FFFE, 0, 65, 1);
        issue(2, SRA, 64'h8000_0000_0000_0000, 64'd63, 0, 0, 2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1);
        drain();

        // Asynchronous reset in the middle of a MUL
        issue(0, MUL, 64'd12345, 64'd678, 0, 0, 24, 64'd0, 0, 33, 0);
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_mid_out_valid", 64'(ovs[0]), 64'd0);
        check("rst_mid_c", {32'b0, c0}, 64'd0);
        check("rst_mid_rd", 64'(rd0), 64'd0);
        check("rst_mid_illegal", 64'(ills[0]), 64'd0);
        check("rst_mid_in_ready", 64'(rdys[0]), 64'd1);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        issue(0, ADD, 64'd2, 64'd3, 0, 0, 1, 64'd5, 0, 0, 1);
        drain();
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
